// File: rtl/aes_entropy_responder_if.sv
// Handshake bundle between the EDN-side genbits source, the entropy responder
// and the AES masking PRNG that consumes the served words.
interface aes_entropy_responder_if #(
  parameter int EntropyWidth = 32,
  parameter int GenBitsWidth = 128
);
  logic                    csrng_req;
  logic                    genbits_valid;
  logic                    genbits_ready;
  logic [GenBitsWidth-1:0] genbits;
  logic                    entropy_req;
  logic                    entropy_ack;
  logic [EntropyWidth-1:0] entropy;

  modport slave (
    output csrng_req, genbits_ready, entropy_ack, entropy,
    input  genbits_valid, genbits, entropy_req
  );

  modport master (
    input  csrng_req, genbits_ready, entropy_ack, entropy,
    output genbits_valid, genbits, entropy_req
  );
endinterface

// File: rtl/aes_entropy_responder.sv
// Buffers genbits blocks from the EDN path and serves them one word per
// acknowledge to the AES PRNG reseed logic; every word is handed out at most once.
module aes_entropy_responder #(
  parameter int EntropyWidth = 32,
  parameter int GenBitsWidth = 128,
  parameter int FifoDepth    = 2,
  parameter int LowWatermark = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  aes_entropy_responder_if.slave bus,
  output logic [15:0]           words_served_o
);
  // state | meaning
  // Idle  | disabled, no upstream request
  // Fill  | requesting genbits until FIFO and unpacker are both full
  // Hold  | request parked until the FIFO drains to LowWatermark

  localparam int NumWords = GenBitsWidth / EntropyWidth;
  localparam int IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int PtrW     = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW     = $clog2(FifoDepth + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [GenBitsWidth-1:0] fifo_mem [FifoDepth];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         fifo_cnt_q;
  logic [GenBitsWidth-1:0] blk_q;
  logic                    blk_valid_q;
  logic [IdxW-1:0]         word_idx_q;

  logic active, fifo_full, fifo_empty, last_word;
  logic ack, push, pop, genbits_ready, csrng_req;

  // Reset is synchronous, so the reset cycle itself must also be kept silent.
  assign active        = enable_i & ~rst_i;
  assign fifo_full     = (fifo_cnt_q == CntW'(FifoDepth));
  assign fifo_empty    = (fifo_cnt_q == '0);
  assign last_word     = (word_idx_q == IdxW'(NumWords - 1));
  assign ack           = active & bus.entropy_req & blk_valid_q;
  assign genbits_ready = active & ~fifo_full;
  assign push          = bus.genbits_valid & genbits_ready;
  assign pop           = active & ~fifo_empty & (~blk_valid_q | (ack & last_word));

  assign bus.genbits_ready = genbits_ready;
  assign bus.entropy_ack   = ack;
  assign bus.entropy       = blk_valid_q ? blk_q[word_idx_q*EntropyWidth +: EntropyWidth]
                                         : '0;
  assign bus.csrng_req     = csrng_req;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    csrng_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i) state_d = StFill;
      end
      StFill: begin
        csrng_req = active;
        if (fifo_full && blk_valid_q) state_d = StHold;
      end
      StHold: begin
        if (fifo_cnt_q <= CntW'(LowWatermark)) state_d = StFill;
      end
      default: state_d = StIdle;
    endcase
    if (!enable_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.genbits;
  end

  // Disable flushes exactly like reset so stale entropy is never served later.
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      blk_valid_q <= 1'b0;
      word_idx_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (pop) begin
        blk_q       <= fifo_mem[rd_ptr_q];
        blk_valid_q <= 1'b1;
        word_idx_q  <= '0;
      end else if (ack) begin
        if (last_word) begin
          blk_valid_q <= 1'b0;
          word_idx_q  <= '0;
        end else begin
          word_idx_q <= word_idx_q + IdxW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      words_served_o <= '0;
    end else if (ack && (words_served_o != 16'hFFFF)) begin
      words_served_o <= words_served_o + 16'd1;
    end
  end

  a_width_multiple: assert property (@(posedge clk_i) (GenBitsWidth % EntropyWidth) == 0);
  a_watermark:      assert property (@(posedge clk_i) LowWatermark < FifoDepth);
  a_ack_needs_req:  assert property (@(posedge clk_i) disable iff (rst_i)
                                     bus.entropy_ack |-> bus.entropy_req);
  a_no_ack_off:     assert property (@(posedge clk_i) !enable_i |-> !bus.entropy_ack);

endmodule

// File: tb/tb_aes_entropy_responder.sv
// Randomised and directed bench for aes_entropy_responder against a queue-based
// model of blocks and words waiting to be served.
module tb_aes_entropy_responder;
  localparam int DEPTH = 2;
  localparam int LOWWM = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] served;

  aes_entropy_responder_if bus ();

  aes_entropy_responder #(
    .EntropyWidth(32),
    .GenBitsWidth(128),
    .FifoDepth(DEPTH),
    .LowWatermark(LOWWM)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(en),
    .bus(bus),
    .words_served_o(served)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: blocks waiting upstream of the unpacker, words left in the current block.
  logic [127:0] m_fifo[$];
  logic [31:0]  m_words[$];
  int           m_state;   // 0 idle, 1 fill, 2 hold
  int           m_served;
  logic         m_ack, m_ready, m_creq;
  logic [31:0]  m_data;

  function automatic logic [127:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function void model_eval();
    m_ack   = en && !rst && bus.entropy_req && (m_words.size() > 0);
    m_data  = (m_words.size() > 0) ? m_words[0] : 32'h0;
    m_ready = en && !rst && (m_fifo.size() < DEPTH);
    m_creq  = en && !rst && (m_state == 1);
  endfunction

  function void model_commit();
    int           cnt;
    bit           full, blkv;
    logic [127:0] blk;
    cnt  = m_fifo.size();
    full = (cnt == DEPTH);
    blkv = (m_words.size() > 0);
    if (rst) begin
      m_fifo.delete(); m_words.delete(); m_state = 0; m_served = 0;
      return;
    end
    if (m_ack) begin
      if (m_served < 65535) m_served++;
      void'(m_words.pop_front());
    end
    if (!en) begin
      m_fifo.delete(); m_words.delete(); m_state = 0;
      return;
    end
    case (m_state)
      0: m_state = 1;
      1: if (full && blkv) m_state = 2;
      default: if (cnt <= LOWWM) m_state = 1;
    endcase
    if (m_words.size() == 0 && cnt > 0) begin
      blk = m_fifo.pop_front();
      for (int k = 0; k < 4; k++) m_words.push_back(blk[k*32 +: 32]);
    end
    if (bus.genbits_valid && m_ready) m_fifo.push_back(bus.genbits);
  endfunction

  task automatic drive(input logic r, input logic e, input logic q, input logic v,
                       input logic [127:0] d);
    rst = r; en = e; bus.entropy_req = q; bus.genbits_valid = v; bus.genbits = d;
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 128'h0);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, rand_blk());
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 128'h0);
    checks++; if (bus.entropy_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", bus.entropy_ack); end
    checks++; if (bus.entropy !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", bus.entropy); end
    checks++; if (bus.genbits_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", bus.genbits_ready); end
    checks++; if (bus.csrng_req !== 1'b0) begin fails++; $display("FAIL reset_creq: got %b want 0", bus.csrng_req); end
    checks++; if (served !== 16'h0) begin fails++; $display("FAIL reset_served: got %h want 0", served); end
    tick();
  endtask

  task automatic test_basic();
    logic [127:0] blk;
    logic [31:0]  got[4];
    bit           sent;
    int           n, first, t_hs;
    blk = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    sent = 0; n = 0; first = -1; t_hs = -1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 1'b1, !sent, blk);
      checks++; if (bus.entropy_ack !== m_ack) begin fails++; $display("FAIL basic_ack c%0d: got %b want %b", i, bus.entropy_ack, m_ack); end
      checks++; if (bus.entropy !== m_data) begin fails++; $display("FAIL basic_data c%0d: got %h want %h", i, bus.entropy, m_data); end
      if (!sent && bus.genbits_ready) begin sent = 1; t_hs = i; end
      if (bus.entropy_ack) begin
        if (n < 4) got[n] = bus.entropy;
        if (first < 0) first = i;
        n++;
      end
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 128'h0);
    checks++; if (n !== 4) begin fails++; $display("FAIL basic_count: got %0d acks want 4", n); end
    for (int k = 0; k < 4 && k < n; k++) begin
      checks++;
      if (got[k] !== 32'h1111_1111 * (k + 1)) begin
        fails++; $display("FAIL basic_word%0d: got %h want %h", k, got[k], 32'h1111_1111 * (k + 1));
      end
    end
    checks++; if (first - t_hs !== 2) begin fails++; $display("FAIL basic_latency: got %0d want 2", first - t_hs); end
    checks++; if (served !== 16'd4) begin fails++; $display("FAIL basic_served: got %0d want 4", served); end
    tick();
  endtask

  task automatic test_req_gaps();
    logic [127:0] blk;
    bit           sent;
    blk = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    sent = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, !sent, blk);
      if (bus.genbits_ready) sent = 1;
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 128'h0);
    checks++; if (bus.entropy_ack !== 1'b1 || bus.entropy !== 32'h1111_1111) begin
      fails++; $display("FAIL gaps_first: got ack %b data %h want 1 11111111", bus.entropy_ack, bus.entropy);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 128'h0);
      checks++; if (bus.entropy_ack !== 1'b0) begin fails++; $display("FAIL gaps_idle c%0d: got %b want 0", i, bus.entropy_ack); end
      checks++; if (bus.entropy !== m_data) begin fails++; $display("FAIL gaps_hold c%0d: got %h want %h", i, bus.entropy, m_data); end
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 128'h0);
    checks++; if (bus.entropy_ack !== 1'b1 || bus.entropy !== 32'h2222_2222) begin
      fails++; $display("FAIL gaps_resume: got ack %b data %h want 1 22222222", bus.entropy_ack, bus.entropy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] blks[3];
    int           pushed, n, first, last;
    bit           was_fill, saw_hold, saw_refill;
    logic [31:0]  exp_w;
    for (int k = 0; k < 3; k++) blks[k] = rand_blk();
    pushed = 0; n = 0; first = -1; last = -1;
    was_fill = 0; saw_hold = 0; saw_refill = 0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b1, 1'b1, pushed < 3, blks[(pushed < 3) ? pushed : 2]);
      checks++; if (bus.entropy_ack !== m_ack) begin fails++; $display("FAIL b2b_ack c%0d: got %b want %b", i, bus.entropy_ack, m_ack); end
      checks++; if (bus.csrng_req !== m_creq) begin fails++; $display("FAIL b2b_creq c%0d: got %b want %b", i, bus.csrng_req, m_creq); end
      if (pushed < 3 && bus.genbits_ready) pushed++;
      if (bus.csrng_req) begin
        if (saw_hold) saw_refill = 1;
        was_fill = 1;
      end else if (was_fill) begin
        saw_hold = 1;
      end
      if (bus.entropy_ack) begin
        exp_w = (n < 12) ? blks[n/4][(n%4)*32 +: 32] : 32'h0;
        checks++; if (bus.entropy !== exp_w) begin fails++; $display("FAIL b2b_word%0d: got %h want %h", n, bus.entropy, exp_w); end
        if (first < 0) first = i;
        last = i;
        n++;
      end
      tick();
    end
    checks++; if (n !== 12) begin fails++; $display("FAIL b2b_count: got %0d want 12", n); end
    checks++; if (last - first !== 11) begin fails++; $display("FAIL b2b_gapless: got span %0d want 11", last - first); end
    checks++; if (!(saw_hold && saw_refill)) begin fails++; $display("FAIL b2b_fsm: got hold %0d refill %0d want 1 1", saw_hold, saw_refill); end
  endtask

  task automatic test_flush();
    logic [127:0] blk_a;
    bit           sent;
    int           n;
    sent = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, !sent, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
      if (bus.genbits_ready) sent = 1;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 128'h0);
      checks++; if (bus.entropy_ack !== m_ack || bus.entropy !== m_data) begin
        fails++; $display("FAIL flush_pre c%0d: got %b %h want %b %h", i, bus.entropy_ack, bus.entropy, m_ack, m_data);
      end
      if (i == 1) begin
        checks++; if (bus.csrng_req !== 1'b1) begin fails++; $display("FAIL flush_creq_before: got %b want 1", bus.csrng_req); end
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, rand_blk());
    checks++; if (bus.csrng_req !== 1'b0) begin fails++; $display("FAIL flush_creq_off: got %b want 0", bus.csrng_req); end
    checks++; if (bus.entropy_ack !== 1'b0) begin fails++; $display("FAIL flush_ack_off: got %b want 0", bus.entropy_ack); end
    checks++; if (bus.genbits_ready !== 1'b0) begin fails++; $display("FAIL flush_ready_off: got %b want 0", bus.genbits_ready); end
    tick();
    blk_a = 128'hAAAA_0004_AAAA_0003_AAAA_0002_AAAA_0001;
    sent = 0; n = 0;
    for (int i = 0; i < 8 && n == 0; i++) begin
      drive(1'b0, 1'b1, 1'b1, !sent, blk_a);
      checks++; if (bus.entropy_ack !== m_ack) begin fails++; $display("FAIL flush_ack c%0d: got %b want %b", i, bus.entropy_ack, m_ack); end
      if (bus.genbits_ready) sent = 1;
      if (bus.entropy_ack) begin
        n++;
        checks++; if (bus.entropy !== 32'hAAAA_0001) begin fails++; $display("FAIL flush_new_word: got %h want aaaa0001", bus.entropy); end
      end
      tick();
    end
    checks++; if (n !== 1) begin fails++; $display("FAIL flush_timeout: got %0d acks want 1", n); end
  endtask

  task automatic test_backpressure();
    logic [127:0] blk_d;
    bit           acc;
    int           acc_at;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, rand_blk());
      checks++; if (bus.genbits_ready !== m_ready) begin fails++; $display("FAIL bp_fill_ready c%0d: got %b want %b", i, bus.genbits_ready, m_ready); end
      tick();
    end
    blk_d = rand_blk();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, blk_d);
      checks++; if (bus.genbits_ready !== 1'b0) begin fails++; $display("FAIL bp_ready c%0d: got %b want 0", i, bus.genbits_ready); end
      checks++; if (bus.csrng_req !== 1'b0) begin fails++; $display("FAIL bp_creq c%0d: got %b want 0", i, bus.csrng_req); end
      tick();
    end
    acc = 0; acc_at = -1;
    for (int j = 0; j < 10; j++) begin
      drive(1'b0, 1'b1, 1'b1, !acc, blk_d);
      checks++; if (bus.genbits_ready !== m_ready) begin fails++; $display("FAIL bp_drain_ready c%0d: got %b want %b", j, bus.genbits_ready, m_ready); end
      checks++; if (bus.entropy !== m_data) begin fails++; $display("FAIL bp_drain_data c%0d: got %h want %h", j, bus.entropy, m_data); end
      if (!acc && bus.genbits_ready) begin acc = 1; acc_at = j; end
      tick();
    end
    checks++; if (acc_at !== 4) begin fails++; $display("FAIL bp_accept_cycle: got %0d want 4", acc_at); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 92, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, rand_blk());
      checks++; if (bus.entropy_ack !== m_ack) begin fails++; $display("FAIL rnd_ack c%0d: got %b want %b", i, bus.entropy_ack, m_ack); end
      checks++; if (bus.entropy !== m_data) begin fails++; $display("FAIL rnd_data c%0d: got %h want %h", i, bus.entropy, m_data); end
      checks++; if (bus.genbits_ready !== m_ready) begin fails++; $display("FAIL rnd_ready c%0d: got %b want %b", i, bus.genbits_ready, m_ready); end
      checks++; if (bus.csrng_req !== m_creq) begin fails++; $display("FAIL rnd_creq c%0d: got %b want %b", i, bus.csrng_req, m_creq); end
      checks++; if (served !== 16'(m_served)) begin fails++; $display("FAIL rnd_served c%0d: got %0d want %0d", i, served, m_served); end
      tick();
    end
  endtask

  task automatic test_saturation();
    int n;
    n = 0;
    do_reset();
    for (int i = 0; i < 70000 && n < 65538; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, rand_blk());
      checks++; if (bus.entropy_ack !== m_ack) begin fails++; $display("FAIL sat_ack c%0d: got %b want %b", i, bus.entropy_ack, m_ack); end
      checks++; if (served !== 16'(m_served)) begin fails++; $display("FAIL sat_served c%0d: got %0d want %0d", i, served, m_served); end
      if (bus.entropy_ack) n++;
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 128'h0);
    checks++; if (n !== 65538) begin fails++; $display("FAIL sat_timeout: got %0d acks want 65538", n); end
    checks++; if (served !== 16'hFFFF) begin fails++; $display("FAIL sat_value: got %h want ffff", served); end
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, rand_blk());
    checks++; if (bus.entropy_ack !== 1'b0) begin fails++; $display("FAIL rst_cycle_ack: got %b want 0", bus.entropy_ack); end
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 128'h0);
    checks++; if (bus.entropy_ack !== 1'b0) begin fails++; $display("FAIL rst_after_ack: got %b want 0", bus.entropy_ack); end
    checks++; if (served !== 16'h0) begin fails++; $display("FAIL rst_after_served: got %h want 0", served); end
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    bus.entropy_req = 1'b0; bus.genbits_valid = 1'b0; bus.genbits = '0;
    m_state = 0; m_served = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_req_gaps();
    test_back_to_back();
    test_flush();
    test_backpressure();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/aes_entropy_responder.md
Name: aes_entropy_responder

Overview:
Responder end of the AES masking-PRNG entropy req/ack interface. Buffers 128-bit genbits blocks from the upstream CSRNG/EDN path and serves them one EntropyWidth word per acknowledge to the PRNG reseed logic. Guarantees every word is delivered at most once and is flushed when disabled. Sits between the EDN endpoint and the AES PRNG inside the AES top.

Parameters:
EntropyWidth, 32, width of each word served downstream (edn_pkg::ENDPOINT_BUS_WIDTH)
GenBitsWidth, 128, width of upstream block; must be a multiple of EntropyWidth
FifoDepth, 2, number of GenBitsWidth blocks buffered ahead of the unpacker (>=1)
LowWatermark, 0, FIFO occupancy at or below which Hold returns to Fill (< FifoDepth)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
enable_i  in  1  block enable; low flushes all stored entropy
csrng_req_o  out  1  level request for more genbits upstream
genbits_valid_i  in  1  upstream block valid
genbits_ready_o  out  1  upstream block ready
genbits_i  in  GenBitsWidth  upstream block data
entropy_req_i  in  1  downstream request (level, held by PRNG)
entropy_ack_o  out  1  downstream acknowledge, one word per high cycle
entropy_o  out  EntropyWidth  downstream word, valid when entropy_ack_o high
words_served_o  out  16  saturating count of acknowledged words

Behaviour:
- Reset: synchronous, sampled on clk_i rising edge with rst_i=1. FIFO empty, unpacker invalid, word_idx=0, FSM=Idle, all outputs 0, words_served_o=0.
- Storage: FIFO of FifoDepth blocks, plus one unpacker register (blk_q, blk_valid_q, word_idx_q, log2(GenBitsWidth/EntropyWidth) bits).
- Upstream: genbits_ready_o = enable_i & ~fifo_full. Block written on valid&ready. No bypass into the unpacker.
- Unpacker load: when enable_i & fifo non-empty & (~blk_valid_q | last-word ack), pop FIFO into blk_q with word_idx_q=0. A same-cycle refill on the last-word ack sustains 1 word/cycle.
- Downstream: entropy_ack_o = enable_i & entropy_req_i & blk_valid_q (combinational from req). entropy_o = blk_q[word_idx_q*EntropyWidth +: EntropyWidth] when blk_valid_q, else 0. Words are served LSB first.
- On ack: word_idx_q increments. On the last word: blk_valid_q=0 unless refilled, word_idx_q wraps to 0.
- Req dropped mid-block: no ack, word_idx_q holds, remaining words are served on the next req.
- Latency: genbits handshake in cycle t, empty unpacker -> earliest entropy_ack_o in cycle t+2.
- FSM (drives csrng_req_o):
  - Idle: csrng_req_o=0. Go to Fill when enable_i=1.
  - Fill: csrng_req_o=1. Go to Hold when fifo_full & blk_valid_q (as seen in the next-state logic).
  - Hold: csrng_req_o=0. Go to Fill when fifo count <= LowWatermark.
  - Any state with enable_i=0 -> Idle.
- Disable: enable_i=0 in a cycle -> at that edge FIFO cleared, blk_valid_q=0, word_idx_q=0. Same cycle: ack=0, genbits_ready_o=0, so no block is accepted or served.
- Simultaneous FIFO push and pop while full: not possible, since ready is low when full. Push and pop while partially full: occupancy unchanged.
- words_served_o: increments on each ack, saturates at 16'hFFFF, cleared only by rst_i. It is not cleared by enable_i.
- Reset mid-stream: all buffered entropy discarded, no ack in the reset cycle.
- Assertions: GenBitsWidth % EntropyWidth == 0; LowWatermark < FifoDepth; entropy_ack_o -> entropy_req_i; no ack while ~enable_i.

Test Plan:
- Basic serve: enable=1, push block 128'h4444_4444_3333_3333_2222_2222_1111_1111, hold req -> acks in 4 consecutive cycles with 32'h1111_1111, 2222_2222, 3333_3333, 4444_4444; words_served_o=4.
- Back-to-back: FifoDepth=2, push 3 blocks, hold req -> 12 acks with no gap cycles; the FSM goes Fill->Hold once the unpacker and FIFO are full, then back to Fill when the FIFO empties.
- Req gaps: after 1 ack, drop req for 5 cycles -> no acks, word_idx held; on re-raising req, the next word is 32'h2222_2222.
- Flush: 2 words served, pulse enable_i low 1 cycle, push new block 128'hA.. -> the first word after re-enable comes from the new block, not 32'h3333_3333; csrng_req_o is 0 during the disabled cycle.
- Backpressure: FIFO full and unpacker valid -> genbits_ready_o=0, csrng_req_o=0. An upstream valid held 10 cycles is not accepted until an unpacker refill frees a FIFO slot.
- Reset/saturation: preload words_served_o near 16'hFFFF via 65535 acks, then 3 more -> stays 16'hFFFF. Assert rst_i mid-block -> ack=0 the next cycle and words_served_o=0.
